alu_ctl_mdu: RTL and testbench

Next-generation EX-stage control for the MIPS pipeline. Registers ALU control decode from op/func on each pipeline advance. Adds an iterative multiply/divide unit (MDU) with HI/LO registers and raises a pipeline stall on HI/LO hazards.

---
 rtl/alu_ctl_mdu.sv | 219 +++++++++++++++++++++
 tb/tb_alu_ctl_mdu.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctl_mdu.sv
// EX-stage ALU control decode plus iterative multiply/divide unit with HI/LO registers.
// Latency: aluc registered 1 cycle after capture; mult/div results land in HI/LO WIDTH+1 cycles after capture.
// Backpressure: stall freezes ID/EX while the MDU is busy and the incoming instruction touches HI/LO or the MDU.
module alu_ctl_mdu #(
    parameter int WIDTH  = 32,
    parameter int ALUC_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [5:0]        op,
    input  logic [5:0]        func,
    input  logic [WIDTH-1:0]  rs_val,
    input  logic [WIDTH-1:0]  rt_val,
    output logic [ALUC_W-1:0] aluc,
    output logic              stall,
    output logic              md_busy,
    output logic              md_done,
    output logic [WIDTH-1:0]  hi,
    output logic [WIDTH-1:0]  lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic [ALUC_W-1:0] dec_aluc;
    logic              dec_hilo;   // any instruction that reads/writes HI/LO or starts the MDU
    logic              dec_md;     // mult/multu/div/divu
    logic              dec_mthi;
    logic              dec_mtlo;
    logic              cap;
    logic              start;

    // MDU working registers
    logic [WIDTH-1:0]  acc;        // product high half / partial remainder
    logic [WIDTH-1:0]  qr;         // multiplier shifting out / quotient shifting in
    logic [WIDTH-1:0]  opb;        // |rt|: multiplicand or divisor magnitude
    logic [WIDTH-1:0]  rs_q;       // original dividend, returned in HI on divide by zero
    logic [CW-1:0]     cnt;
    logic              md_div;
    logic              md_sgn;
    logic              sa;
    logic              sb;
    logic              rt_zero;

    logic [WIDTH-1:0]  rs_abs;
    logic [WIDTH-1:0]  rt_abs;
    logic [WIDTH:0]    mul_sum;
    logic [WIDTH:0]    div_sh;
    logic              div_ge;
    logic [WIDTH-1:0]  div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]  fix_hi;
    logic [WIDTH-1:0]  fix_lo;

    // Decode op/func into the ALU control code and HI/LO hazard class
    always_comb begin
        dec_aluc = '0;
        dec_hilo = 1'b0;
        dec_md   = 1'b0;
        dec_mthi = 1'b0;
        dec_mtlo = 1'b0;
        if (op == 6'b000000) begin
            case (func)
                6'b100000: dec_aluc = ALUC_W'(0);
                6'b100010: dec_aluc = ALUC_W'(1);
                6'b100100: dec_aluc = ALUC_W'(2);
                6'b100101: dec_aluc = ALUC_W'(3);
                6'b100110: dec_aluc = ALUC_W'(4);
                6'b101010: dec_aluc = ALUC_W'(5);
                6'b100111: dec_aluc = ALUC_W'(14);
                6'b000000: dec_aluc = ALUC_W'(6);
                6'b000100: dec_aluc = ALUC_W'(7);
                6'b000011: dec_aluc = ALUC_W'(8);
                6'b000111: dec_aluc = ALUC_W'(9);
                6'b000010: dec_aluc = ALUC_W'(10);
                6'b000110: dec_aluc = ALUC_W'(11);
                6'b010000: begin dec_aluc = ALUC_W'(15); dec_hilo = 1'b1; end
                6'b010010: begin dec_aluc = ALUC_W'(16); dec_hilo = 1'b1; end
                6'b010001: begin dec_aluc = ALUC_W'(17); dec_hilo = 1'b1; dec_mthi = 1'b1; end
                6'b010011: begin dec_aluc = ALUC_W'(18); dec_hilo = 1'b1; dec_mtlo = 1'b1; end
                6'b011000: begin dec_aluc = ALUC_W'(19); dec_hilo = 1'b1; dec_md = 1'b1; end
                6'b011001: begin dec_aluc = ALUC_W'(20); dec_hilo = 1'b1; dec_md = 1'b1; end
                6'b011010: begin dec_aluc = ALUC_W'(21); dec_hilo = 1'b1; dec_md = 1'b1; end
                6'b011011: begin dec_aluc = ALUC_W'(22); dec_hilo = 1'b1; dec_md = 1'b1; end
                default:   dec_aluc = '0;
            endcase
        end else begin
            case (op)
                6'b001000: dec_aluc = ALUC_W'(0);
                6'b001100: dec_aluc = ALUC_W'(2);
                6'b001101: dec_aluc = ALUC_W'(3);
                6'b001010: dec_aluc = ALUC_W'(5);
                6'b001111: dec_aluc = ALUC_W'(13);
                default:   dec_aluc = '0;
            endcase
        end
    end

    assign md_busy = (state == RUN) || (state == FIX);
    assign md_done = (state == DONE);
    assign stall   = md_busy & en & dec_hilo;
    assign cap     = en & ~stall;
    assign start   = cap & dec_md;

    // Capture ALU control on each unstalled advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aluc <= '0;
        end else if (cap) begin
            aluc <= dec_aluc;
        end
    end

    // MDU state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // MDU next state; a new op may start straight from DONE since stall is already low there
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == CW'(1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = start ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operand magnitudes and one iteration step for each algorithm
    always_comb begin
        rs_abs   = (~func[0] & rs_val[WIDTH-1]) ? -rs_val : rs_val;
        rt_abs   = (~func[0] & rt_val[WIDTH-1]) ? -rt_val : rt_val;
        mul_sum  = {1'b0, acc} + (qr[0] ? {1'b0, opb} : '0);
        div_sh   = {acc, qr[WIDTH-1]};
        div_ge   = div_sh >= {1'b0, opb};
        div_diff = div_sh[WIDTH-1:0] - opb;
    end

    // Sign correction and special cases applied in FIX
    always_comb begin
        prod   = {acc, qr};
        fix_hi = acc;
        fix_lo = qr;
        if (!md_div) begin
            if (md_sgn && (sa ^ sb)) begin
                prod = -prod;
            end
            fix_hi = prod[2*WIDTH-1:WIDTH];
            fix_lo = prod[WIDTH-1:0];
        end else if (rt_zero) begin
            fix_hi = rs_q;
            fix_lo = '1;
        end else begin
            if (md_sgn && (sa ^ sb)) fix_lo = -qr;
            if (md_sgn && sa)        fix_hi = -acc;
        end
    end

    // Latch operands on start, then iterate one bit per RUN cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            qr      <= '0;
            opb     <= '0;
            rs_q    <= '0;
            cnt     <= '0;
            md_div  <= 1'b0;
            md_sgn  <= 1'b0;
            sa      <= 1'b0;
            sb      <= 1'b0;
            rt_zero <= 1'b0;
        end else if (start) begin
            acc     <= '0;
            qr      <= rs_abs;
            opb     <= rt_abs;
            rs_q    <= rs_val;
            cnt     <= CW'(WIDTH);
            md_div  <= func[1];
            md_sgn  <= ~func[0];
            sa      <= ~func[0] & rs_val[WIDTH-1];
            sb      <= ~func[0] & rt_val[WIDTH-1];
            rt_zero <= (rt_val == '0);
        end else if (state == RUN) begin
            cnt <= cnt - CW'(1);
            if (md_div) begin
                acc <= div_ge ? div_diff : div_sh[WIDTH-1:0];
                qr  <= {qr[WIDTH-2:0], div_ge};
            end else begin
                acc <= mul_sum[WIDTH:1];
                qr  <= {mul_sum[0], qr[WIDTH-1:1]};
            end
        end
    end

    // HI/LO: MDU result in FIX, mthi/mtlo on capture (never both, capture is stalled in FIX)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (state == FIX) begin
            hi <= fix_hi;
            lo <= fix_lo;
        end else begin
            if (cap && dec_mthi) hi <= rs_val;
            if (cap && dec_mtlo) lo <= rs_val;
        end
    end

endmodule

// File: tb/tb_alu_ctl_mdu.sv
module tb_alu_ctl_mdu;

    logic        clk;
    logic        rst;
    logic        en;
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [4:0]  aluc;
    logic        stall;
    logic        md_busy;
    logic        md_done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   errors = 0;

    alu_ctl_mdu #(.WIDTH(32), .ALUC_W(5)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .op      (op),
        .func    (func),
        .rs_val  (rs_val),
        .rt_val  (rt_val),
        .aluc    (aluc),
        .stall   (stall),
        .md_busy (md_busy),
        .md_done (md_done),
        .hi      (hi),
        .lo      (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference results for the MDU operations, including the architectural corner cases
    function automatic res_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        res_t        r;
        logic [63:0] p;
        r = '0;
        case (f)
            6'h18: begin
                p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            6'h19: begin
                p = {32'b0, a} * {32'b0, b};
                r.hi = p[63:32];
                r.lo = p[31:0];
            end
            6'h1a: begin
                if (b == 32'd0) begin
                    r.hi = a;
                    r.lo = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.hi = 32'd0;
                    r.lo = 32'h8000_0000;
                end else begin
                    r.lo = $signed(a) / $signed(b);
                    r.hi = $signed(a) % $signed(b);
                end
            end
            default: begin
                if (b == 32'd0) begin
                    r.hi = a;
                    r.lo = 32'hFFFF_FFFF;
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
        endcase
        return r;
    endfunction

    task automatic issue(input logic [5:0] o, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        op     = o;
        func   = f;
        rs_val = a;
        rt_val = b;
        en     = 1'b1;
        tick();
        en     = 1'b0;
    endtask

    task automatic issue_md(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        sb.push_back(model(f, a, b));
        issue(6'b000000, f, a, b);
    endtask

    task automatic pop_cmp(input string tag);
        res_t e;
        check({tag, "_sbsize"}, sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_hi"}, hi, e.hi);
            check({tag, "_lo"}, lo, e.lo);
        end
    endtask

    task automatic wait_done(input string tag, output int lat);
        lat = 0;
        while (!md_done && lat < 200) begin
            tick();
            lat++;
        end
        check({tag, "_done"}, md_done, 1);
        pop_cmp(tag);
    endtask

    initial begin
        int lat;
        int n;

        rst = 1'b1; en = 1'b0; op = '0; func = '0; rs_val = '0; rt_val = '0;
        tick();
        check("rst_aluc", aluc, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_busy", md_busy, 0);
        check("rst_done", md_done, 0);
        rst = 1'b0;
        tick();

        // ALU control decode
        issue(6'b000000, 6'b100010, 0, 0); check("dec_sub", aluc, 1);
        issue(6'b000000, 6'b100000, 0, 0); check("dec_add", aluc, 0);
        issue(6'b001111, 6'b000000, 0, 0); check("dec_lui", aluc, 13);
        op = 6'b000000; func = 6'b100100; en = 1'b0;
        tick();                            check("dec_hold", aluc, 13);
        issue(6'b001100, 6'b000000, 0, 0); check("dec_andi", aluc, 2);
        issue(6'b000000, 6'b100111, 0, 0); check("dec_nor", aluc, 14);
        issue(6'b000000, 6'b000111, 0, 0); check("dec_srav", aluc, 9);
        issue(6'b100011, 6'b100010, 0, 0); check("dec_other", aluc, 0);

        // mthi/mtlo while idle
        issue(6'b000000, 6'b010001, 32'h1234, 0); check("mthi_idle", hi, 32'h1234);
        issue(6'b000000, 6'b010011, 32'h5678, 0); check("mtlo_idle", lo, 32'h5678);

        // multiply / divide results through the scoreboard
        issue_md(6'h19, 32'hFFFF_FFFF, 32'd2);
        check("multu_aluc", aluc, 20);
        check("multu_busy", md_busy, 1);
        wait_done("multu", lat);
        check("multu_lat", lat, 33);
        issue_md(6'h1a, 32'hFFFF_FFF9, 32'd2);  wait_done("div_neg", lat);
        issue_md(6'h1b, 32'd5, 32'd0);          wait_done("divu_z", lat);
        issue_md(6'h18, 32'hFFFF_FFFD, 32'd5);  wait_done("mult_neg", lat);
        issue_md(6'h1a, 32'h8000_0000, 32'hFFFF_FFFF); wait_done("div_ovf", lat);
        issue_md(6'h1a, 32'd100, 32'hFFFF_FFF9); wait_done("div_negb", lat);
        issue_md(6'h1a, 32'h0000_0011, 32'd0);  wait_done("div_z", lat);

        // mult, intervening add proceeds, then mflo stalls until DONE
        issue_md(6'h18, 32'd7, 32'd6);
        op = 6'b000000; func = 6'b100000; en = 1'b1;
        #1;
        check("add_nostall", stall, 0);
        tick();
        check("add_aluc", aluc, 0);
        func = 6'b010010;
        #1;
        n = 0;
        while (stall && n < 100) begin
            tick();
            n++;
        end
        check("mflo_stall_cycles", n, 32);
        check("mflo_done", md_done, 1);
        pop_cmp("mult_mflo");
        tick();
        en = 1'b0;
        check("mflo_aluc", aluc, 16);

        // mthi while busy waits for DONE and HI is untouched until then
        issue(6'b000000, 6'b010001, 32'h1234, 0); check("mthi_idle2", hi, 32'h1234);
        issue_md(6'h19, 32'h0001_0000, 32'h0003_0000);
        op = 6'b000000; func = 6'b010001; rs_val = 32'hABCD; en = 1'b1;
        #1;
        check("mthi_stall", stall, 1);
        for (int i = 0; i < 10; i++) tick();
        check("mthi_hi_held", hi, 32'h1234);
        n = 0;
        while (stall && n < 100) begin
            tick();
            n++;
        end
        check("mthi_done", md_done, 1);
        pop_cmp("multu_mthi");
        tick();
        en = 1'b0;
        check("mthi_busy_hi", hi, 32'hABCD);

        // asynchronous reset in the middle of RUN
        issue(6'b000000, 6'b011000, 32'd7, 32'd6);
        for (int i = 0; i < 5; i++) tick();
        check("pre_rst_busy", md_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_aluc", aluc, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        check("arst_busy", md_busy, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        check("post_rst_lo", lo, 0);
        check("post_rst_done", md_done, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
